pad_frame_writer: RTL

//  Write side of the padded frame buffer used by the 3x3 window reader. Accepts a raw IMG_W x IMG_H

---
 rtl/pad_writer_pkg.sv | 26 ++
 rtl/pad_frame_writer_pos.sv | 43 ++++
 rtl/pad_frame_writer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pad_writer_pkg.sv
// Shared types and constants for the padded frame writer: FSM states,
// default geometry and the checksum width.
package pad_writer_pkg;

   localparam int DEF_IMG_W = 256;
   localparam int DEF_IMG_H = 256;
   localparam int DEF_PAD_W = DEF_IMG_W + 2;
   localparam int DEF_PAD_H = DEF_IMG_H + 2;
   localparam int CSUM_W    = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TOP    = 3'd1,
      LEFT   = 3'd2,
      BODY   = 3'd3,
      RIGHT  = 3'd4,
      BOTTOM = 3'd5,
      DONE   = 3'd6
   } state_t;

   // Padded dimension for an active dimension of n pixels.
   function automatic int pad_dim(input int n);
      return n + 2;
   endfunction

endpackage

// File: rtl/pad_frame_writer_pos.sv
// Column/row position counters for the padded frame writer. The column wraps
// at a caller-supplied terminal value so that border rows and body rows share it.
module pad_pos_counter #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int CW    = $clog2(IMG_W + 2),
   parameter int RW    = $clog2(IMG_H + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          col_en_i,
   input  logic          row_en_i,
   input  logic [CW-1:0] col_max_i,
   output logic          eol_o,
   output logic          eof_o
);

   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;

   assign eol_o = (col_q == col_max_i);
   assign eof_o = (row_q == RW'(IMG_H - 1));

   // Position registers: clear on frame start, column wraps at its terminal value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= {CW{1'b0}};
         row_q <= {RW{1'b0}};
      end else if (clr_i) begin
         col_q <= {CW{1'b0}};
         row_q <= {RW{1'b0}};
      end else begin
         if (col_en_i) begin
            col_q <= eol_o ? {CW{1'b0}} : col_q + CW'(1);
         end
         if (row_en_i) begin
            row_q <= row_q + RW'(1);
         end
      end
   end

endmodule

// File: rtl/pad_frame_writer.sv
// Writes a raw raster frame into memory surrounded by a one-pixel zero border.
// Optional macro FRAME_CHECKSUM_EN adds a 16-bit sum of accepted body pixels.
module pad_frame_writer
   import pad_writer_pkg::*;
#(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              s_valid,
   input  logic [PIX_W-1:0]  s_pixel,
   output logic              s_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [PIX_W-1:0]  mem_wdata,
   output logic              busy,
   output logic              done
`ifdef FRAME_CHECKSUM_EN
   ,output logic [CSUM_W-1:0] checksum
`endif
);

   localparam int PAD_W = pad_dim(IMG_W);
   localparam int CW    = $clog2(IMG_W + 2);

   state_t            state_q, state_d;
   logic              slot_s;
   logic [PIX_W-1:0]  wdata_s;
   logic              clr_s, col_en_s, row_en_s;
   logic [CW-1:0]     col_max_s;
   logic              eol_s, eof_s;
   logic [ADDR_W-1:0] waddr_q;
   logic              mem_we_q, busy_q, done_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [PIX_W-1:0]  mem_wdata_q;

   pad_pos_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) u_pos (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (clr_s),
      .col_en_i  (col_en_s),
      .row_en_i  (row_en_s),
      .col_max_i (col_max_s),
      .eol_o     (eol_s),
      .eof_o     (eof_s)
   );

   assign s_ready = (state_q == BODY);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and per-cycle write slot; border slots always carry zero data.
   always_comb begin
      state_d   = state_q;
      slot_s    = 1'b0;
      wdata_s   = {PIX_W{1'b0}};
      clr_s     = 1'b0;
      col_en_s  = 1'b0;
      row_en_s  = 1'b0;
      col_max_s = CW'(PAD_W - 1);
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = TOP;
               clr_s   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         TOP: begin
            slot_s   = 1'b1;
            col_en_s = 1'b1;
            if (eol_s) begin
               state_d = LEFT;
            end else begin
               state_d = TOP;
            end
         end
         LEFT: begin
            slot_s  = 1'b1;
            state_d = BODY;
         end
         BODY: begin
            col_max_s = CW'(IMG_W - 1);
            if (s_valid) begin
               slot_s   = 1'b1;
               wdata_s  = s_pixel;
               col_en_s = 1'b1;
               if (eol_s) begin
                  state_d = RIGHT;
               end else begin
                  state_d = BODY;
               end
            end else begin
               state_d = BODY;
            end
         end
         RIGHT: begin
            slot_s = 1'b1;
            if (eof_s) begin
               state_d = BOTTOM;
            end else begin
               row_en_s = 1'b1;
               state_d  = LEFT;
            end
         end
         BOTTOM: begin
            slot_s   = 1'b1;
            col_en_s = 1'b1;
            if (eol_s) begin
               state_d = DONE;
            end else begin
               state_d = BOTTOM;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered write port, status flags and the linear write address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waddr_q     <= {ADDR_W{1'b0}};
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {PIX_W{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         mem_we_q <= slot_s;
         busy_q   <= (state_d != IDLE);
         done_q   <= (state_q == DONE);
         if (slot_s) begin
            mem_addr_q  <= waddr_q;
            mem_wdata_q <= wdata_s;
         end
         if (clr_s) begin
            waddr_q <= {ADDR_W{1'b0}};
         end else if (slot_s) begin
            waddr_q <= waddr_q + ADDR_W'(1);
         end
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef FRAME_CHECKSUM_EN
   logic [CSUM_W-1:0] csum_q;

   // Running sum of accepted body pixels, held after the frame completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= {CSUM_W{1'b0}};
      end else if (clr_s) begin
         csum_q <= {CSUM_W{1'b0}};
      end else if (s_ready && s_valid) begin
         csum_q <= csum_q + CSUM_W'(s_pixel);
      end
   end

   assign checksum = csum_q;
`endif

endmodule
